// File: rtl/mem_write_ctrl_if.sv
// Write-side fill bus for mem_write_ctrl: input word handshake, memory write port, status.
// The checksum signal exists only when MEM_WR_CHECKSUM_EN is defined.
interface mem_write_ctrl_if #(
    parameter int ADRS_WIDTH = 2,
    parameter int WORD_WIDTH = 8
);
    logic                  start;
    logic                  in_valid;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADRS_WIDTH-1:0] mem_adrs;
    logic [WORD_WIDTH-1:0] mem_d;
    logic                  busy;
    logic                  done;
    logic [ADRS_WIDTH:0]   count;
`ifdef MEM_WR_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] checksum;
`endif

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_adrs, mem_d, busy, done, count
`ifdef MEM_WR_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_adrs, mem_d, busy, done, count
`ifdef MEM_WR_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/mem_write_ctrl.sv
// Sequential memory fill controller: accepts WORD_DEPTH words and writes them to addresses 0..N-1.
// Optional running XOR of the burst on checksum when MEM_WR_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, count holds last burst result
// FILL  | accepting words, one registered write per accept
// DONE  | single cycle, done pulse alongside the final write
module mem_write_ctrl #(
    parameter int ADRS_WIDTH = 2,
    parameter int WORD_DEPTH = 4,
    parameter int WORD_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    mem_write_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADRS_WIDTH-1:0] LAST_PTR = ADRS_WIDTH'(WORD_DEPTH - 1);
    localparam logic [ADRS_WIDTH:0]   LAST_CNT = (ADRS_WIDTH + 1)'(WORD_DEPTH - 1);

    logic [1:0]            state;
    logic [ADRS_WIDTH-1:0] ptr;
    logic                  mem_we;
    logic [ADRS_WIDTH-1:0] mem_adrs;
    logic [WORD_WIDTH-1:0] mem_d;
    logic [ADRS_WIDTH:0]   count;
`ifdef MEM_WR_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] checksum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            mem_we   <= 1'b0;
            mem_adrs <= '0;
            mem_d    <= '0;
            count    <= '0;
`ifdef MEM_WR_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= FILL;
                        ptr   <= '0;
                        count <= '0;
`ifdef MEM_WR_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                FILL: begin
                    // in_ready is 1 throughout FILL, so in_valid alone marks an accept
                    if (bus.in_valid) begin
                        mem_we   <= 1'b1;
                        mem_adrs <= ptr;
                        mem_d    <= bus.in_data;
                        ptr      <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
                        count    <= count + 1'b1;
`ifdef MEM_WR_CHECKSUM_EN
                        checksum <= checksum ^ bus.in_data;
`endif
                        if (count == LAST_CNT) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state == FILL);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.mem_we   = mem_we;
    assign bus.mem_adrs = mem_adrs;
    assign bus.mem_d    = mem_d;
    assign bus.count    = count;
`ifdef MEM_WR_CHECKSUM_EN
    assign bus.checksum = checksum;
`endif
endmodule

// File: tb/tb_mem_write_ctrl.sv
// Scoreboard bench for mem_write_ctrl: expected writes queued at drive time, popped on mem_we.
module tb_mem_write_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_write_ctrl_if #(.ADRS_WIDTH(2), .WORD_WIDTH(8)) bus ();

    mem_write_ctrl #(.ADRS_WIDTH(2), .WORD_DEPTH(4), .WORD_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [1:0] adrs;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    wr_t        exp_wr;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mem_model [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk)
        if (bus.mem_we === 1'b1) mem_model[bus.mem_adrs] <= bus.mem_d;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_we", 32'(bus.mem_we), 32'd0);
            end else begin
                exp_wr = sb.pop_front();
                chk("wr_adrs", 32'(bus.mem_adrs), 32'(exp_wr.adrs));
                chk("wr_data", 32'(bus.mem_d), 32'(exp_wr.data));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
        chk({tag, "_busy"},     32'(bus.busy),     32'd0);
        chk({tag, "_done"},     32'(bus.done),     32'd0);
        chk({tag, "_mem_adrs"}, 32'(bus.mem_adrs), 32'd0);
        chk({tag, "_mem_d"},    32'(bus.mem_d),    32'd0);
        chk({tag, "_count"},    32'(bus.count),    32'd0);
`ifdef MEM_WR_CHECKSUM_EN
        chk({tag, "_checksum"}, 32'(bus.checksum), 32'd0);
`endif
    endtask

    // One full burst; gap idle cycles between words, optional ignored start after word 2
    task automatic burst(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] w3, input int gap, input bit extra_start,
                         input string tag);
        logic [7:0] w [4];
        logic [7:0] cs;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        cs = 8'h00;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(bus.busy),     32'd1);
        chk({tag, "_ready"},     32'(bus.in_ready), 32'd1);
        chk({tag, "_count0"},    32'(bus.count),    32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            sb.push_back(wr_t'{adrs: 2'(i), data: w[i]});
            cs = cs ^ w[i];
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_data  = 8'h00;
            if (i < 3) begin
                chk({tag, "_no_early_done"}, 32'(bus.done), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    if (extra_start && i == 1 && g == 0) bus.start = 1'b1;
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                    chk({tag, "_busy_gap"}, 32'(bus.busy), 32'd1);
                end
            end
        end
        chk({tag, "_done"},       32'(bus.done),     32'd1);
        chk({tag, "_count4"},     32'(bus.count),    32'd4);
        chk({tag, "_busy_done"},  32'(bus.busy),     32'd1);
        chk({tag, "_ready_done"}, 32'(bus.in_ready), 32'd0);
`ifdef MEM_WR_CHECKSUM_EN
        chk({tag, "_checksum"},   32'(bus.checksum), 32'(cs));
`endif
        @(posedge clk); #1;
        chk({tag, "_done_fall"},  32'(bus.done),  32'd0);
        chk({tag, "_busy_fall"},  32'(bus.busy),  32'd0);
        chk({tag, "_count_hold"}, 32'(bus.count), 32'd4);
        chk({tag, "_sb_empty"},   32'(sb.size()), 32'd0);
        for (int i = 0; i < 4; i++)
            chk({tag, "_readback"}, 32'(mem_model[i]), 32'(w[i]));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid_we",   32'(bus.mem_we),   32'd0);
        chk("idle_valid_busy", 32'(bus.busy),     32'd0);
        chk("idle_ready",      32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        burst(8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0, "b2b");
        burst(8'hA0, 8'hB1, 8'hC2, 8'hD3, 2, 1'b0, "gap");
        burst(8'h10, 8'h20, 8'h30, 8'h40, 2, 1'b1, "ign_start");

        // Abort after two accepted words, then refill from address 0
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hC0 + 8'(i);
            sb.push_back(wr_t'{adrs: 2'(i), data: 8'hC0 + 8'(i)});
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
        burst(8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 1'b0, "after_rst");

        burst(8'hA5, 8'h5A, 8'hFF, 8'h00, 1, 1'b0, "cs_zero");
        burst(8'h01, 8'h02, 8'h04, 8'h08, 0, 1'b0, "cs_0f");

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
